// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-RAM bus between the MEM stage and data memory
//   req   : bus request, held until ack
//   we    : 1 = store
//   addr  : word-aligned byte address
//   sel   : little-endian byte-lane enables
//   wdata : store data, replicated across lanes
//   ack   : transaction complete, rdata valid in the same cycle
//   rdata : read data
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, we, addr, sel, wdata, input ack, rdata);
   modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage and MEM/WB register, runs loads/stores on a req/ack RAM bus
//   clk, rst (async, active low)
//   mem_op, result_in, store_data, write_reg_*_in, write_hilo_*_in : from EX
//   flush                      : pipeline flush from control
//   ram (mem_stage_if.master)  : data-RAM bus
//   mem_stall_request          : combinational stall to pipeline control
//   wb_*                       : registered register and HI/LO writes to WB
//   addr_error                 : registered one-cycle misalignment pulse
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mem_op,
   input  logic [31:0] result_in,
   input  logic [31:0] store_data,
   input  logic        write_reg_en_in,
   input  logic [4:0]  write_reg_addr_in,
   input  logic        write_hilo_en_in,
   input  logic [31:0] write_hi_data_in,
   input  logic [31:0] write_lo_data_in,
   input  logic        flush,
   mem_stage_if.master ram,
   output logic        mem_stall_request,
   output logic        wb_write_reg_en,
   output logic [4:0]  wb_write_reg_addr,
   output logic [31:0] wb_result,
   output logic        wb_write_hilo_en,
   output logic [31:0] wb_hi_data,
   output logic [31:0] wb_lo_data,
   output logic        addr_error
);
   localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                          OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state, state_nx;
   logic [1:0]  a, a_q;
   logic        is_byte, is_half, is_word, is_mem, misaligned, start, ack_w, drop, drop_e;
   logic [3:0]  sel_c, op_q;
   logic [31:0] wdata_c, load_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        wen_q, hilo_q;
   logic [4:0]  waddr_q;
   logic [31:0] hi_q, lo_q;
   assign a          = result_in[1:0];
   assign is_byte    = mem_op == OP_LB || mem_op == OP_LBU || mem_op == OP_SB;
   assign is_half    = mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH;
   assign is_word    = mem_op == OP_LW || mem_op == OP_SW;
   assign is_mem     = is_byte | is_half | is_word;
   assign misaligned = (is_half & a[0]) | (is_word & (a != 2'b00));
   assign start      = state == IDLE && is_mem && !misaligned && !flush;
   assign ack_w      = state == WAIT && ram.ack;
   // a flush on the ack cycle itself also discards the result
   assign drop_e     = drop | flush;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   // stall is forced low during reset so an abandoned transaction releases the pipeline at once
   always_comb begin
      state_nx          = start ? WAIT : ack_w ? IDLE : state;
      mem_stall_request = rst & (start | (state == WAIT && !ram.ack));
   end
   always_comb begin
      sel_c     = is_word ? 4'b1111 : is_half ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
      wdata_c   = is_word ? store_data : is_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
      byte_v    = ram.rdata[{a_q, 3'b000} +: 8];
      half_v    = a_q[1] ? ram.rdata[31:16] : ram.rdata[15:0];
      load_data = op_q == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                  op_q == OP_LBU ? {24'd0, byte_v} :
                  op_q == OP_LH  ? {{16{half_v[15]}}, half_v} :
                  op_q == OP_LHU ? {16'd0, half_v} : ram.rdata;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ram.req           <= 1'b0;
         ram.we            <= 1'b0;
         ram.addr          <= '0;
         ram.sel           <= '0;
         ram.wdata         <= '0;
         wb_write_reg_en   <= 1'b0;
         wb_write_reg_addr <= '0;
         wb_result         <= '0;
         wb_write_hilo_en  <= 1'b0;
         wb_hi_data        <= '0;
         wb_lo_data        <= '0;
         addr_error        <= 1'b0;
         drop              <= 1'b0;
         op_q              <= '0;
         a_q               <= '0;
         wen_q             <= 1'b0;
         waddr_q           <= '0;
         hilo_q            <= 1'b0;
         hi_q              <= '0;
         lo_q              <= '0;
      end else if (state == IDLE) begin
         // memory ops, misaligned ops and flushes all leave a bubble; data fields are don't-care then
         wb_write_reg_en   <= !flush && !is_mem && write_reg_en_in;
         wb_write_hilo_en  <= !flush && !is_mem && write_hilo_en_in;
         wb_write_reg_addr <= write_reg_addr_in;
         wb_result         <= result_in;
         wb_hi_data        <= write_hi_data_in;
         wb_lo_data        <= write_lo_data_in;
         addr_error        <= !flush && misaligned;
         drop              <= 1'b0;
         if (start) begin
            ram.req   <= 1'b1;
            ram.we    <= mem_op == OP_SB || mem_op == OP_SH || mem_op == OP_SW;
            ram.addr  <= {result_in[31:2], 2'b00};
            ram.sel   <= sel_c;
            ram.wdata <= wdata_c;
            op_q      <= mem_op;
            a_q       <= a;
            wen_q     <= write_reg_en_in;
            waddr_q   <= write_reg_addr_in;
            hilo_q    <= write_hilo_en_in;
            hi_q      <= write_hi_data_in;
            lo_q      <= write_lo_data_in;
         end
      end else if (ram.ack) begin
         ram.req           <= 1'b0;
         wb_write_reg_en   <= !drop_e && !ram.we && wen_q;
         wb_write_hilo_en  <= !drop_e && hilo_q;
         wb_write_reg_addr <= waddr_q;
         wb_result         <= load_data;
         wb_hi_data        <= hi_q;
         wb_lo_data        <= lo_q;
         addr_error        <= 1'b0;
         drop              <= 1'b0;
      end else begin
         wb_write_reg_en  <= 1'b0;
         wb_write_hilo_en <= 1'b0;
         addr_error       <= 1'b0;
         drop             <= drop | flush;
      end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  mem_op = '0;
   logic [31:0] result_in = '0, store_data = '0, write_hi_data_in = '0, write_lo_data_in = '0;
   logic        write_reg_en_in = 1'b0, write_hilo_en_in = 1'b0, flush = 1'b0;
   logic [4:0]  write_reg_addr_in = '0;
   logic        mem_stall_request, wb_write_reg_en, wb_write_hilo_en, addr_error;
   logic [4:0]  wb_write_reg_addr;
   logic [31:0] wb_result, wb_hi_data, wb_lo_data;
   int          checks = 0, errors = 0;
   mem_stage_if ram ();
   mem_stage dut (
      .clk(clk), .rst(rst), .mem_op(mem_op), .result_in(result_in), .store_data(store_data),
      .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
      .write_hilo_en_in(write_hilo_en_in), .write_hi_data_in(write_hi_data_in),
      .write_lo_data_in(write_lo_data_in), .flush(flush), .ram(ram),
      .mem_stall_request(mem_stall_request), .wb_write_reg_en(wb_write_reg_en),
      .wb_write_reg_addr(wb_write_reg_addr), .wb_result(wb_result),
      .wb_write_hilo_en(wb_write_hilo_en), .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data),
      .addr_error(addr_error)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic int op_size(input logic [3:0] op);
      return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 :
             (op == 5 || op == 8) ? 4 : 0;
   endfunction
   function automatic logic [31:0] exp_load(input logic [3:0] op, input int a, input logic [31:0] rd);
      logic [31:0] v;
      int sz;
      sz = op_size(op);
      if (sz == 4) return rd;
      v = (rd >> (8 * a)) & ((32'd1 << (8 * sz)) - 1);
      if ((op == 1 && v >= 32'h80) || (op == 3 && v >= 32'h8000)) v = v | ~((32'd1 << (8 * sz)) - 1);
      return v;
   endfunction
   function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] sd);
      return sz == 1 ? {24'd0, sd[7:0]} * 32'h01010101 :
             sz == 2 ? {16'd0, sd[15:0]} * 32'h00010001 : sd;
   endfunction
   // one instruction starting just after a negedge; k = wait cycles before ack,
   // fl_at = WAIT-cycle index carrying flush (-1 none); returns just after a negedge
   task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int k, input bit fl_idle, input int fl_at,
                        input bit we_en, input logic [4:0] wa, input bit hl_en,
                        input logic [31:0] hi, input logic [31:0] lo);
      int  sz, stalls;
      bit  mem, mis, load, drop, exp_en;
      sz   = op_size(op);
      mem  = sz != 0;
      mis  = mem && (addr % sz) != 0;
      load = op >= 1 && op <= 5;
      mem_op = op; result_in = addr; store_data = sd; write_reg_en_in = we_en;
      write_reg_addr_in = wa; write_hilo_en_in = hl_en; write_hi_data_in = hi;
      write_lo_data_in = lo; flush = fl_idle;
      #1;
      if (!mem || mis || fl_idle) begin
         check("idle_stall", mem_stall_request, 0);
         @(negedge clk);
         flush = 1'b0;
         exp_en = !mem && !fl_idle;
         check("idle_req", ram.req, 0);
         check("addr_error", addr_error, mis && !fl_idle);
         check("wb_reg_en", wb_write_reg_en, exp_en && we_en);
         check("wb_hilo_en", wb_write_hilo_en, exp_en && hl_en);
         if (exp_en && we_en) begin
            check("wb_result", wb_result, addr);
            check("wb_reg_addr", wb_write_reg_addr, wa);
         end
         if (exp_en && hl_en) begin
            check("wb_hi", wb_hi_data, hi);
            check("wb_lo", wb_lo_data, lo);
         end
         if (mis && !fl_idle) begin
            mem_op = 0; write_reg_en_in = 0; write_hilo_en_in = 0;
            @(negedge clk);
            check("addr_error_pulse", addr_error, 0);
            check("after_mis_req", ram.req, 0);
         end
         return;
      end
      check("start_stall", mem_stall_request, 1);
      stalls = 1;
      drop = 0;
      for (int i = 0; i <= k; i++) begin
         @(negedge clk);
         check("wait_req", ram.req, 1);
         check("wait_we", ram.we, !load);
         check("wait_addr", ram.addr, addr & ~32'd3);
         check("wait_sel", ram.sel, ((32'd1 << sz) - 1) << (addr % 4));
         if (!load) check("wait_wdata", ram.wdata, exp_wdata(sz, sd));
         check("wait_wb_en", wb_write_reg_en | wb_write_hilo_en, 0);
         result_in = $urandom; store_data = $urandom; mem_op = 4'($urandom);
         flush = i == fl_at;
         if (i == fl_at) drop = 1;
         ram.ack = i == k;
         ram.rdata = i == k ? rd : $urandom;
         #1;
         check("wait_stall", mem_stall_request, i != k);
         stalls += int'(mem_stall_request);
      end
      @(negedge clk);
      ram.ack = 1'b0; flush = 1'b0; mem_op = 0;
      check("stall_cycles", stalls, k + 1);
      check("ack_req", ram.req, 0);
      check("ack_addr_error", addr_error, 0);
      exp_en = !drop && load && we_en;
      check("ack_wb_reg_en", wb_write_reg_en, exp_en);
      check("ack_wb_hilo_en", wb_write_hilo_en, !drop && hl_en);
      if (exp_en) begin
         check("ack_wb_result", wb_result, exp_load(op, addr % 4, rd));
         check("ack_wb_reg_addr", wb_write_reg_addr, wa);
      end
      if (!drop && hl_en) begin
         check("ack_wb_hi", wb_hi_data, hi);
         check("ack_wb_lo", wb_lo_data, lo);
      end
   endtask
   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, ram.req, 0);
      check({tag, "_we"}, ram.we, 0);
      check({tag, "_addr"}, ram.addr, 0);
      check({tag, "_sel"}, ram.sel, 0);
      check({tag, "_wdata"}, ram.wdata, 0);
      check({tag, "_stall"}, mem_stall_request, 0);
      check({tag, "_wb_en"}, {wb_write_reg_en, wb_write_hilo_en}, 0);
      check({tag, "_wb_result"}, wb_result, 0);
      check({tag, "_wb_addr"}, wb_write_reg_addr, 0);
      check({tag, "_wb_hilo"}, wb_hi_data | wb_lo_data, 0);
      check({tag, "_addr_error"}, addr_error, 0);
   endtask
   initial begin
      ram.ack = 1'b0;
      ram.rdata = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      do_op(5, 32'h100, 0, 32'h12345678, 3, 0, -1, 1, 5'd3, 0, 0, 0);
      do_op(1, 32'h203, 0, 32'h80AABBCC, 0, 0, -1, 1, 5'd4, 0, 0, 0);
      do_op(2, 32'h203, 0, 32'h80AABBCC, 0, 0, -1, 1, 5'd4, 0, 0, 0);
      do_op(7, 32'h302, 32'h0000BEEF, 0, 1, 0, -1, 1, 5'd5, 0, 0, 0);
      do_op(5, 32'h402, 0, 0, 0, 0, -1, 1, 5'd6, 0, 0, 0);
      do_op(0, 32'hDEADBEEF, 0, 0, 0, 0, -1, 1, 5'd7, 1, 32'h1, 32'h2);
      do_op(5, 32'h500, 0, 32'hCAFEF00D, 3, 0, 1, 1, 5'd8, 1, 32'h3, 32'h4);
      do_op(5, 32'h600, 0, 0, 0, 1, -1, 1, 5'd9, 1, 32'h5, 32'h6);
      mem_op = 5; result_in = 32'h700; write_reg_en_in = 1; write_reg_addr_in = 5'd10;
      @(negedge clk);
      mem_op = 0;
      @(negedge clk);
      check("pre_reset_req", ram.req, 1);
      rst = 1'b0;
      #1;
      check_all_zero("mid_wait_reset");
      @(negedge clk);
      rst = 1'b1;
      do_op(0, 32'h11112222, 0, 0, 0, 0, -1, 1, 5'd11, 0, 0, 0);
      do_op(4, 32'h802, 0, 32'h9876FEDC, 2, 0, -1, 1, 5'd12, 0, 0, 0);
      for (int n = 0; n < 300; n++) begin
         logic [3:0]  op;
         logic [31:0] addr;
         int          k, sz, fl_at;
         bit          fl_idle;
         op    = 4'($urandom_range(0, 15));
         addr  = $urandom;
         sz    = op_size(op);
         k     = $urandom_range(0, 4);
         fl_idle = (sz == 0 || addr % sz == 0) && $urandom_range(0, 9) == 0;
         fl_at = $urandom_range(0, 5) == 0 ? $urandom_range(0, k) : -1;
         do_op(op, addr, $urandom, $urandom, k, fl_idle, fl_at, 1'($urandom), 5'($urandom),
               1'($urandom), $urandom, $urandom);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
